// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches under a two-credit
// limit, holds returned words in a 2-entry in-order buffer for decode, and
// discards responses that belong to a path flushed by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_address
);

  // Fetch pointer and the addresses of requests still in flight
  logic [31:0] pc;
  logic [31:0] af_addr [2];
  logic        af_rd;
  logic        af_wr;

  // Delivery buffer, head-indexed, holding {address, instruction}
  logic [31:0] buf_addr [2];
  logic [31:0] buf_insn [2];
  logic        head;
  logic [1:0]  count;

  // In-flight bookkeeping. drop_cnt is one bit wider than the nominal
  // 0..2 range so back-to-back redirects against a slow memory cannot wrap it.
  logic [1:0]  outstanding;
  logic [2:0]  drop_cnt;

  logic        issue;
  logic        pop;
  logic        accept;
  logic        tail;
  logic [2:0]  credit_used;
  logic [31:0] redirect_target;
  logic [31:0] reset_target;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign reset_target    = RESET_PC & 32'hFFFF_FFFC;
  assign imem_addr       = pc;

  // Handshake qualifiers and the credit rule. A pop in this cycle frees its
  // slot, which is what lets a single-cycle memory stream one word per cycle.
  always_comb begin
    pop         = 1'b0;
    accept      = 1'b0;
    imem_req    = 1'b0;
    tail        = head ^ count[0];
    if ((count != 2'd0) && !stall && !redirect) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
    if (imem_rvalid && (drop_cnt == 3'd0) && !redirect) begin
      accept = 1'b1;
    end else begin
      accept = 1'b0;
    end
    credit_used = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};
    if (rst) begin
      imem_req = 1'b0;
    end else if (redirect) begin
      imem_req = 1'b0;
    end else if (credit_used < 3'd2) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
    issue = imem_req & imem_ready;
  end

  // Decode-facing view of the buffer head
  always_comb begin
    valid       = (count != 2'd0);
    instruction = NOP_INSN;
    pc_address  = 32'h0000_0000;
    if (valid) begin
      instruction = buf_insn[head];
      pc_address  = buf_addr[head];
    end else begin
      instruction = NOP_INSN;
      pc_address  = 32'h0000_0000;
    end
  end

  // Fetch pointer advance/redirect and the in-flight address FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= reset_target;
      af_rd      <= 1'b0;
      af_wr      <= 1'b0;
      af_addr[0] <= 32'h0000_0000;
      af_addr[1] <= 32'h0000_0000;
    end else if (redirect) begin
      pc    <= redirect_target;
      af_rd <= 1'b0;
      af_wr <= 1'b0;
    end else begin
      if (issue) begin
        pc             <= pc + 32'd4;
        af_addr[af_wr] <= pc;
        af_wr          <= ~af_wr;
      end
      if (accept) begin
        af_rd <= ~af_rd;
      end
    end
  end

  // Delivery buffer push/pop; a redirect empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= 1'b0;
      count       <= 2'd0;
      buf_addr[0] <= 32'h0000_0000;
      buf_addr[1] <= 32'h0000_0000;
      buf_insn[0] <= 32'h0000_0000;
      buf_insn[1] <= 32'h0000_0000;
    end else if (redirect) begin
      head  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (accept) begin
        buf_addr[tail] <= af_addr[af_rd];
        buf_insn[tail] <= imem_rdata;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= count + {1'b0, accept} - {1'b0, pop};
    end
  end

  // Outstanding and flushed-path response counters. On redirect every
  // pending response (old drops plus live requests, less one returning now)
  // becomes a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 2'd0;
      drop_cnt    <= 3'd0;
    end else if (redirect) begin
      outstanding <= 2'd0;
      drop_cnt    <= drop_cnt + {1'b0, outstanding} + {2'b00, issue}
                     - {2'b00, imem_rvalid};
    end else begin
      outstanding <= outstanding + {1'b0, issue} - {1'b0, accept};
      if (imem_rvalid && (drop_cnt != 3'd0)) begin
        drop_cnt <= drop_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model with adjustable
// latency answers fetches with addr ^ 32'hA000_0000; expected deliveries are
// queued by the stimulus and checked by a monitor on each accepted head.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] pc_address;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int t     = 0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] insn; } exp_t;
  pend_t pend [$];
  exp_t  exp_q [$];

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid(valid), .instruction(instruction), .pc_address(pc_address)
  );

  always #5 clk = ~clk;

  // Absolute cycle counter for the memory model
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic expect_insn(input logic [31:0] pc, input logic [31:0] insn);
    exp_t e;
    e.pc = pc;
    e.insn = insn;
    exp_q.push_back(e);
  endtask

  // Advance to relative cycle c, landing 1 ns after its rising edge
  task automatic at(input int c);
    while (t < c) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  // Memory model: record each issue with its due cycle
  always @(negedge clk) begin
    if (!rst && imem_req && imem_ready) begin
      pend_t p;
      p.addr = imem_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
    end
  end

  // Memory model: return responses in order once due
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend[0].addr ^ 32'hA000_0000;
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: every head accepted by decode must match the next expectation
  always @(negedge clk) begin
    if (!rst && valid && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h insn %h, want nothing", pc_address, instruction);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", pc_address, e.pc);
        chk("sb_insn", instruction, e.insn);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_insn", instruction, 32'h0000_0013);
    chk("rst_pcaddr", pc_address, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);

    // Stream from reset, then stall with 0x8 and 0xC buffered
    expect_insn(32'h0, 32'hA000_0000);
    expect_insn(32'h4, 32'hA000_0004);
    expect_insn(32'h8, 32'hA000_0008);
    expect_insn(32'hC, 32'hA000_000C);
    rst = 1'b0;
    #1;
    t = 0;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    at(2); chk("stream_pc0", pc_address, 32'h0); chk("stream_v0", {31'd0, valid}, 32'd1);
    at(3); chk("stream_pc4", pc_address, 32'h4);
    at(4); chk("stream_pc8", pc_address, 32'h8);
    stall = 1'b1;
    for (int c = 5; c <= 6; c++) begin
      at(c);
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_pc", pc_address, 32'h8);
      chk("stall_insn", instruction, 32'hA000_0008);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    at(7); stall = 1'b0; imem_ready = 1'b0;
    at(8); chk("after_stall_pc", pc_address, 32'hC);
    at(9);
    chk("idle_valid", {31'd0, valid}, 32'd0);
    chk("idle_insn", instruction, 32'h0000_0013);
    chk("idle_pcaddr", pc_address, 32'h0);

    // Redirect to 0x100 with two requests outstanding (3-cycle memory)
    expect_insn(32'h100, 32'hA000_0100);
    expect_insn(32'h104, 32'hA000_0104);
    lat = 3; imem_ready = 1'b1;
    at(11); redirect = 1'b1; redirect_pc = 32'h100;
    at(12); redirect = 1'b0;
    #1;
    chk("rdr_req", {31'd0, imem_req}, 32'd1);
    chk("rdr_addr", imem_addr, 32'h100);
    at(14); imem_ready = 1'b0;
    at(15); chk("rdr_wait_valid", {31'd0, valid}, 32'd0);
    at(16); chk("rdr_valid", {31'd0, valid}, 32'd1); chk("rdr_pc", pc_address, 32'h100);

    // Redirect in the same cycle a response returns (2-cycle memory)
    expect_insn(32'h200, 32'hA000_0200);
    at(18); lat = 2; imem_ready = 1'b1;
    at(20); redirect = 1'b1; redirect_pc = 32'h200;
    at(21); redirect = 1'b0;
    at(22); imem_ready = 1'b0;
    at(24); chk("samecyc_pc", pc_address, 32'h200);

    // Redirect to the top word (unaligned request) and wrap to zero
    expect_insn(32'hFFFF_FFFC, 32'h5FFF_FFFC);
    expect_insn(32'h0, 32'hA000_0000);
    expect_insn(32'h4, 32'hA000_0004);
    expect_insn(32'h8, 32'hA000_0008);
    at(25); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; lat = 1; imem_ready = 1'b1;
    at(26); redirect = 1'b0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    at(28); chk("wrap_pc0", pc_address, 32'hFFFF_FFFC);
    at(29); chk("wrap_pc1", pc_address, 32'h0);
    at(30); imem_ready = 1'b0; chk("wrap_pc2", pc_address, 32'h4);
    at(31); chk("wrap_pc3", pc_address, 32'h8);

    // Reset while a word is live and one request is outstanding
    at(32); imem_ready = 1'b1;
    at(34);
    chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    chk("pre_rst_pc", pc_address, 32'hC);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_insn", instruction, 32'h0000_0013);
    chk("mid_rst_pcaddr", pc_address, 32'h0);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    expect_insn(32'h0, 32'hA000_0000);
    expect_insn(32'h4, 32'hA000_0004);
    at(36); rst = 1'b0;
    #1;
    chk("rerel_req", {31'd0, imem_req}, 32'd1);
    chk("rerel_addr", imem_addr, 32'h0);
    at(38); imem_ready = 1'b0;
    chk("rerel_pc", pc_address, 32'h0);
    chk("rerel_insn", instruction, 32'hA000_0000);
    at(39); chk("rerel_pc4", pc_address, 32'h4);

    at(42);
    chk("sb_left", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
